// File: rtl/rs232_pkg.sv
// rs232_pkg: constants and types shared by the RS232 receiver and transmitter.
//   CLKS_PER_BIT_DEFAULT : clock cycles per bit at 50 MHz / 115200 baud
//   DATA_BITS            : payload bits per frame (8N1, LSB first)
//   rxState_t            : receiver FSM state encoding
package rs232_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned BIT_IDX_W            = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    s_idle,
    s_start,
    s_data,
    s_stop,
    s_wait
  } rxState_t;

endpackage

// File: rtl/rs232_sync.sv
// rs232_sync: two-flop synchroniser for an asynchronous single-bit input.
//   clk        : destination clock
//   rst        : asynchronous active-low reset, loads RESET_VAL into both flops
//   d          : asynchronous input
//   q          : synchronised output (two clk cycles of latency)
module rs232_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Plain two-stage shift; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: 8N1 UART receiver, LSB first, idle-high line.
//   CLKS_PER_BIT : clock cycles per bit, must be >= 4
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   rx           : serial line from the pin, asynchronous to clk
//   dataOut      : last correctly framed byte, held until the next good byte
//   dataValid    : one-cycle pulse, dataOut updated this cycle
//   frameErr     : one-cycle pulse, stop bit sampled low
//   busy         : high whenever the receiver is not idle
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  output logic                 frameErr,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST  = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_ONE   = BIT_IDX_W'(1);

  logic                 rxS;

  rxState_t             state;
  rxState_t             stateNext;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cntNext;
  logic [BIT_IDX_W-1:0] idx;
  logic [BIT_IDX_W-1:0] idxNext;
  logic [DATA_BITS-1:0] shiftReg;
  logic [DATA_BITS-1:0] shiftNext;
  logic [DATA_BITS-1:0] dataNext;
  logic                 validNext;
  logic                 errNext;
  logic                 busyNext;

  // Bring the pin into the clk domain; idle level is high.
  rs232_sync #(
    .RESET_VAL (1'b1)
  ) uSync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxS)
  );

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= s_idle;
      cnt       <= '0;
      idx       <= '0;
      shiftReg  <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      frameErr  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      idx       <= idxNext;
      shiftReg  <= shiftNext;
      dataOut   <= dataNext;
      dataValid <= validNext;
      frameErr  <= errNext;
      busy      <= busyNext;
    end
  end

  // Next-state and next-output logic; every transition clears the bit counter.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    idxNext   = idx;
    shiftNext = shiftReg;
    dataNext  = dataOut;
    validNext = 1'b0;
    errNext   = 1'b0;

    unique case (state)
      s_idle: begin
        cntNext = '0;
        idxNext = '0;
        if (!rxS) begin
          stateNext = s_start;
        end
      end

      // Re-check the start bit at its centre to reject short glitches.
      s_start: begin
        if (cnt == HALF_LAST) begin
          cntNext   = '0;
          stateNext = rxS ? s_idle : s_data;
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end

      // From the start-bit centre, every full bit period lands mid-bit.
      s_data: begin
        if (cnt == BIT_LAST) begin
          cntNext        = '0;
          shiftNext[idx] = rxS;
          if (idx == IDX_LAST) begin
            stateNext = s_stop;
          end else begin
            idxNext = idx + IDX_ONE;
          end
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end

      s_stop: begin
        if (cnt == BIT_LAST) begin
          cntNext = '0;
          if (rxS) begin
            dataNext  = shiftReg;
            validNext = 1'b1;
            stateNext = s_idle;
          end else begin
            errNext   = 1'b1;
            stateNext = s_wait;
          end
        end else begin
          cntNext = cnt + CNT_ONE;
        end
      end

      // Line held low (break): wait for idle so only one frameErr is reported.
      s_wait: begin
        cntNext = '0;
        if (rxS) begin
          stateNext = s_idle;
        end
      end

      default: begin
        cntNext   = '0;
        idxNext   = '0;
        stateNext = s_idle;
      end
    endcase

    busyNext = (stateNext != s_idle);
  end

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: scoreboard bench for rs232_rx.
//   Instance A uses CLKS_PER_BIT=16 for directed and random skewed traffic,
//   instance B uses the default 434 for random traffic.
//   A behavioural transmitter drives each rx line and queues the expected
//   event; per-instance monitors pop and compare on every output pulse.
module tb_rs232_rx;

  localparam int CPB_A = 16;
  localparam int CPB_B = 434;

  typedef struct {
    bit         isErr;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxA = 1'b1;
  logic       rxB = 1'b1;
  logic [7:0] dataOutA, dataOutB;
  logic       dataValidA, dataValidB;
  logic       frameErrA, frameErrB;
  logic       busyA, busyB;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  ev_t         expA[$];
  ev_t         expB[$];
  logic [7:0]  lastA = 8'h00;
  logic [7:0]  lastB = 8'h00;
  int unsigned validCycA = 0;
  bit          prevPulseA = 1'b0;
  bit          prevPulseB = 1'b0;

  rs232_rx #(.CLKS_PER_BIT(CPB_A)) uDutA (
    .clk       (clk),
    .rst       (rst),
    .rx        (rxA),
    .dataOut   (dataOutA),
    .dataValid (dataValidA),
    .frameErr  (frameErrA),
    .busy      (busyA)
  );

  rs232_rx uDutB (
    .clk       (clk),
    .rst       (rst),
    .rx        (rxB),
    .dataOut   (dataOutB),
    .dataValid (dataValidB),
    .frameErr  (frameErrB),
    .busy      (busyB)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for instance A.
  always @(negedge clk) begin
    ev_t ev;
    if (!rst) begin
      prevPulseA = 1'b0;
    end else begin
      if (dataValidA || frameErrA) begin
        check("A exclusive pulses", 64'(dataValidA && frameErrA), 0);
        check("A consecutive pulse", 64'(prevPulseA), 0);
        if (dataValidA) validCycA = cyc;
        checks++;
        if (expA.size() == 0) begin
          failures++;
          $display("FAIL A unexpected pulse: valid=%0b err=%0b data=0x%0h, want no pulse",
                   dataValidA, frameErrA, dataOutA);
        end else begin
          ev = expA.pop_front();
          check("A pulse kind (frameErr)", 64'(frameErrA), 64'(ev.isErr));
          check("A dataOut", 64'(dataOutA), 64'(ev.data));
        end
      end
      prevPulseA = dataValidA || frameErrA;
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    ev_t ev;
    if (!rst) begin
      prevPulseB = 1'b0;
    end else begin
      if (dataValidB || frameErrB) begin
        check("B exclusive pulses", 64'(dataValidB && frameErrB), 0);
        check("B consecutive pulse", 64'(prevPulseB), 0);
        checks++;
        if (expB.size() == 0) begin
          failures++;
          $display("FAIL B unexpected pulse: valid=%0b err=%0b data=0x%0h, want no pulse",
                   dataValidB, frameErrB, dataOutB);
        end else begin
          ev = expB.pop_front();
          check("B pulse kind (frameErr)", 64'(frameErrB), 64'(ev.isErr));
          check("B dataOut", 64'(dataOutB), 64'(ev.data));
        end
      end
      prevPulseB = dataValidB || frameErrB;
    end
  end

  // Behavioural transmitter: start, 8 data bits LSB first, stop. Bit edges are
  // placed at round(k * cpb * (1 + skew/1000)) cycles from the frame start.
  // Must be called at a negedge; leaves rx at the stop-bit level.
  task automatic sendFrame(input bit useB, input logic [7:0] b, input int skewPm,
                           input bit stopLow, input bit track);
    int         cpb;
    logic [9:0] bits;
    int         prevEnd;
    int         bEnd;
    ev_t        ev;
    cpb     = useB ? CPB_B : CPB_A;
    bits    = {~stopLow, b, 1'b0};
    prevEnd = 0;
    if (track) begin
      if (useB) begin
        ev.isErr = stopLow;
        ev.data  = stopLow ? lastB : b;
        if (!stopLow) lastB = b;
        expB.push_back(ev);
      end else begin
        ev.isErr = stopLow;
        ev.data  = stopLow ? lastA : b;
        if (!stopLow) lastA = b;
        expA.push_back(ev);
      end
    end
    for (int k = 0; k < 10; k++) begin
      if (useB) rxB = bits[k];
      else      rxA = bits[k];
      bEnd = ((k + 1) * cpb * (1000 + skewPm) + 500) / 1000;
      repeat (bEnd - prevEnd) @(negedge clk);
      prevEnd = bEnd;
    end
  endtask

  initial begin
    int unsigned startCyc;
    int          skews[2];
    logic [7:0]  b2b[3];

    skews = '{20, -20};
    b2b   = '{8'h00, 8'hFF, 8'h55};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset dataOutA", 64'(dataOutA), 0);
    check("reset dataValidA", 64'(dataValidA), 0);
    check("reset frameErrA", 64'(frameErrA), 0);
    check("reset busyA", 64'(busyA), 0);
    check("reset dataOutB", 64'(dataOutB), 0);
    check("reset busyB", 64'(busyB), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Basic byte with exact pulse timing: t0 = startCyc+1, pulse at t0+154.
    startCyc = cyc;
    sendFrame(1'b0, 8'hA5, 0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("basic dataValid cycle", 64'(validCycA), 64'(startCyc + 155));
    check("basic dataOut", 64'(dataOutA), 64'hA5);

    // Back-to-back frames with baud skew.
    foreach (skews[s]) begin
      foreach (b2b[i]) sendFrame(1'b0, b2b[i], skews[s], 1'b0, 1'b1);
      repeat (40) @(negedge clk);
    end
    check("b2b final dataOut", 64'(dataOutA), 64'h55);

    // Glitch shorter than half a bit: busy high after t0+9, low after t0+10.
    startCyc = cyc;
    rxA = 1'b0;
    repeat (5) @(negedge clk);
    rxA = 1'b1;
    repeat (5) @(negedge clk);
    check("glitch busy before check", 64'(busyA), 1);
    @(negedge clk);
    check("glitch busy after check", 64'(busyA), 0);
    check("glitch cycle alignment", 64'(cyc), 64'(startCyc + 11));
    check("glitch dataOut kept", 64'(dataOutA), 64'h55);

    // Framing error followed by a long break.
    sendFrame(1'b0, 8'h3C, 0, 1'b1, 1'b1);
    repeat (40 * CPB_A) @(negedge clk);
    check("break busy held", 64'(busyA), 1);
    check("break dataOut kept", 64'(dataOutA), 64'h55);
    rxA = 1'b1;
    repeat (2) @(negedge clk);
    check("break release busy still high", 64'(busyA), 1);
    @(negedge clk);
    check("break release busy low", 64'(busyA), 0);
    repeat (20) @(negedge clk);

    // Reset during data bit 4 of 0x81; held until the aborted frame has passed.
    fork
      sendFrame(1'b0, 8'h81, 0, 1'b0, 1'b0);
      begin
        repeat (88) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("async reset dataOutA", 64'(dataOutA), 0);
        check("async reset dataValidA", 64'(dataValidA), 0);
        check("async reset frameErrA", 64'(frameErrA), 0);
        check("async reset busyA", 64'(busyA), 0);
      end
    join
    lastA = 8'h00;
    lastB = 8'h00;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    sendFrame(1'b0, 8'h81, 0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("post-reset dataOut", 64'(dataOutA), 64'h81);

    // Random traffic, CLKS_PER_BIT=16, +/-2% skew, random idle gaps.
    for (int i = 0; i < 40; i++) begin
      sendFrame(1'b0, 8'($urandom), int'($urandom_range(40, 0)) - 20, 1'b0, 1'b1);
      repeat ($urandom_range(20, 0)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    // Random traffic, default CLKS_PER_BIT, +/-2.5% skew.
    for (int i = 0; i < 10; i++) begin
      sendFrame(1'b1, 8'($urandom), int'($urandom_range(50, 0)) - 25, 1'b0, 1'b1);
      repeat ($urandom_range(50, 0)) @(negedge clk);
    end
    repeat (1000) @(negedge clk);

    check("A expected events drained", 64'(expA.size()), 0);
    check("B expected events drained", 64'(expB.size()), 0);
    check("B final dataOut", 64'(dataOutB), 64'(lastB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
